// File: rtl/i2c_line_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// i2c_line_conditioner_pkg : shared constants and bus-state type
// Rev 1.0
// ============================================================================
package i2c_line_conditioner_pkg;

    localparam int I2C_FILTER_WIDTH = 4;
    localparam int I2C_IDLE_TIMEOUT = 1000;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } BusState;

endpackage
`default_nettype wire

// File: rtl/i2c_line_conditioner_if.sv
`default_nettype none
// ============================================================================
// i2c_line_conditioner_if : pad inputs, filter setting and conditioned outputs
// Rev 1.0
// ============================================================================
interface i2c_line_conditioner_if
    import i2c_line_conditioner_pkg::*;
#(
    parameter int FILTER_WIDTH = I2C_FILTER_WIDTH
);
    logic                    SDA_in;
    logic                    SCL_in;
    logic [FILTER_WIDTH-1:0] filter_len;
    logic                    SDA_sync;
    logic                    SCL_sync;
    logic                    start_detected;
    logic                    stop_detected;
    logic                    bus_busy;
    logic                    timeout_event;

    modport master (
        output SDA_in, SCL_in, filter_len,
        input  SDA_sync, SCL_sync, start_detected, stop_detected, bus_busy, timeout_event
    );

    modport slave (
        input  SDA_in, SCL_in, filter_len,
        output SDA_sync, SCL_sync, start_detected, stop_detected, bus_busy, timeout_event
    );
endinterface
`default_nettype wire

// File: rtl/i2c_line_conditioner_glitch_filter.sv
`default_nettype none
// ============================================================================
// i2c_glitch_filter : two-flop synchroniser plus persistence-counter filter
// Rev 1.0
// ============================================================================
module i2c_glitch_filter
    import i2c_line_conditioner_pkg::*;
#(
    parameter int FILTER_WIDTH = I2C_FILTER_WIDTH
) (
    input  wire logic                    clk,
    input  wire logic                    n_rst,
    input  wire logic                    line_i,
    input  wire logic [FILTER_WIDTH-1:0] filter_len_i,
    output logic                         line_o
);
    logic                    sync1_q;
    logic                    sync2_q;
    logic                    filt_q;
    logic                    filt_d;
    logic [FILTER_WIDTH-1:0] cnt_q;
    logic [FILTER_WIDTH-1:0] cnt_d;

    // A new level is accepted once it has been seen filter_len+1 times in a row.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == filter_len_i) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + FILTER_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign line_o = filt_q;

endmodule
`default_nettype wire

// File: rtl/i2c_line_conditioner.sv
`default_nettype none
// ============================================================================
// i2c_line_conditioner : SDA/SCL sync + glitch filter, START/STOP detect, busy
// Optional lost-STOP recovery built when I2C_BUS_TIMEOUT_EN is defined.
// Rev 1.0
// ============================================================================
module i2c_line_conditioner
    import i2c_line_conditioner_pkg::*;
#(
    parameter int FILTER_WIDTH = I2C_FILTER_WIDTH,
    parameter int IDLE_TIMEOUT = I2C_IDLE_TIMEOUT
) (
    input  wire logic              clk,
    input  wire logic              n_rst,
    i2c_line_conditioner_if.slave  bus
);
    logic    sda_f;
    logic    scl_f;
    logic    sda_prev_q;
    logic    scl_prev_q;
    logic    w_start;
    logic    w_stop;
    logic    w_timeout;
    BusState state_q;
    BusState state_d;
    logic    start_q;
    logic    stop_q;

    i2c_glitch_filter #(.FILTER_WIDTH(FILTER_WIDTH)) u_sda_filter (
        .clk          (clk),
        .n_rst        (n_rst),
        .line_i       (bus.SDA_in),
        .filter_len_i (bus.filter_len),
        .line_o       (sda_f)
    );

    i2c_glitch_filter #(.FILTER_WIDTH(FILTER_WIDTH)) u_scl_filter (
        .clk          (clk),
        .n_rst        (n_rst),
        .line_i       (bus.SCL_in),
        .filter_len_i (bus.filter_len),
        .line_o       (scl_f)
    );

    // SCL must be high both before and after, so a coincident SCL edge masks SDA.
    assign w_start = scl_prev_q & scl_f &  sda_prev_q & ~sda_f;
    assign w_stop  = scl_prev_q & scl_f & ~sda_prev_q &  sda_f;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_start) state_d = BUSY;
            BUSY:    if (w_stop || w_timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sda_prev_q <= 1'b1;
            scl_prev_q <= 1'b1;
            state_q    <= IDLE;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            sda_prev_q <= sda_f;
            scl_prev_q <= scl_f;
            state_q    <= state_d;
            start_q    <= w_start;
            stop_q     <= w_stop;
        end
    end

`ifdef I2C_BUS_TIMEOUT_EN
    logic [15:0] idle_q;
    logic [15:0] idle_d;
    logic        timeout_q;

    // Fires on the cycle the count of idle-high BUSY cycles reaches IDLE_TIMEOUT.
    always_comb begin
        idle_d    = '0;
        w_timeout = 1'b0;
        if (state_q == BUSY && sda_f && scl_f) begin
            if (idle_q + 16'd1 == 16'(IDLE_TIMEOUT)) begin
                w_timeout = 1'b1;
            end else begin
                idle_d = idle_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            timeout_q <= w_timeout & ~w_stop;
        end
    end

    assign bus.timeout_event = timeout_q;
`else
    logic w_unused_timeout;
    assign w_unused_timeout  = (IDLE_TIMEOUT == 0);
    assign w_timeout         = 1'b0;
    assign bus.timeout_event = 1'b0;
`endif

    assign bus.SDA_sync       = sda_f;
    assign bus.SCL_sync       = scl_f;
    assign bus.start_detected = start_q;
    assign bus.stop_detected  = stop_q;
    assign bus.bus_busy       = (state_q == BUSY);

endmodule
`default_nettype wire

// File: tb/tb_i2c_line_conditioner.sv
`default_nettype none
// ============================================================================
// tb_i2c_line_conditioner : scoreboard bench for the I2C line conditioner
// Timeout scenario follows I2C_BUS_TIMEOUT_EN. Rev 1.0
// ============================================================================
module tb_i2c_line_conditioner;

    localparam int c_IDLE_TIMEOUT = 20;
    localparam int c_EV_START     = 1;
    localparam int c_EV_STOP      = 2;
    localparam int c_EV_TMO       = 3;

    typedef struct {
        int kind;
        int busy;
        int cyc;
    } ev_t;

    logic clk;
    logic n_rst;
    int   checks;
    int   errors;
    int   cyc;
    int   fl;
    int   last_fall_cyc;
    int   mon_kind;
    int   prev_pulse;
    int   prev_sda_sync;
    int   t0;
    int   t1;
    ev_t  sb_q[$];
    ev_t  mon_ev;

    i2c_line_conditioner_if #(.FILTER_WIDTH(4)) bus ();

    i2c_line_conditioner #(
        .FILTER_WIDTH (4),
        .IDLE_TIMEOUT (c_IDLE_TIMEOUT)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int busy, input int cyc_exp);
        ev_t e;
        e.kind = kind;
        e.busy = busy;
        e.cyc  = cyc_exp;
        sb_q.push_back(e);
    endtask

    // Drive both pads on a falling edge, queue the expected event, then settle.
    task automatic set_lines(input logic sda, input logic scl, input int kind, input int busy);
        @(negedge clk);
        if (kind != 0) push(kind, busy, cyc + fl + 4);
        bus.SDA_in = sda;
        bus.SCL_in = scl;
        repeat (fl + 8) @(negedge clk);
    endtask

    // Monitor: every pulse pops one expected event from the scoreboard.
    always @(posedge clk) begin
        #1;
        mon_kind = bus.start_detected ? c_EV_START :
                   bus.stop_detected  ? c_EV_STOP  :
                   bus.timeout_event  ? c_EV_TMO   : 0;
        if (mon_kind != 0) begin
            check("pulse_width", prev_pulse, 0);
            if (sb_q.size() == 0) begin
                check("unexpected_event", mon_kind, 0);
            end else begin
                mon_ev = sb_q.pop_front();
                check("ev_kind", mon_kind, mon_ev.kind);
                check("ev_busy", int'(bus.bus_busy), mon_ev.busy);
                if (mon_ev.cyc >= 0) check("ev_cycle", cyc, mon_ev.cyc);
            end
        end
        prev_pulse = (mon_kind != 0) ? 1 : 0;
        if (prev_sda_sync == 1 && bus.SDA_sync == 1'b0) last_fall_cyc = cyc;
        prev_sda_sync = int'(bus.SDA_sync);
    end

    initial begin
        checks        = 0;
        errors        = 0;
        cyc           = 0;
        fl            = 3;
        last_fall_cyc = -1;
        prev_pulse    = 0;
        prev_sda_sync = 1;
        n_rst          = 1'b0;
        bus.SDA_in     = 1'b0;
        bus.SCL_in     = 1'b0;
        bus.filter_len = 4'd3;

        repeat (3) @(posedge clk);
        #1;
        check("rst_sda_sync", int'(bus.SDA_sync), 1);
        check("rst_scl_sync", int'(bus.SCL_sync), 1);
        check("rst_start", int'(bus.start_detected), 0);
        check("rst_stop", int'(bus.stop_detected), 0);
        check("rst_busy", int'(bus.bus_busy), 0);
        check("rst_timeout", int'(bus.timeout_event), 0);
        @(negedge clk);
        bus.SDA_in = 1'b1;
        bus.SCL_in = 1'b1;
        repeat (4) @(negedge clk);
        n_rst = 1'b1;
        repeat (10) @(negedge clk);

        // 3-cycle glitch must be rejected at filter_len = 3
        bus.SDA_in = 1'b0;
        repeat (3) @(negedge clk);
        bus.SDA_in = 1'b1;
        repeat (12) @(negedge clk);
        check("glitch_reject", last_fall_cyc, -1);
        check("glitch_level", int'(bus.SDA_sync), 1);

        // 4-cycle low with SCL high: accepted, giving a START then a STOP
        @(negedge clk);
        t0 = cyc;
        push(c_EV_START, 1, t0 + fl + 4);
        bus.SDA_in = 1'b0;
        repeat (4) @(negedge clk);
        t1 = cyc;
        push(c_EV_STOP, 0, t1 + fl + 4);
        bus.SDA_in = 1'b1;
        repeat (14) @(negedge clk);
        check("sda_latency", last_fall_cyc - t0, 2 + fl + 1);
        check("idle_after_stop", int'(bus.bus_busy), 0);

        // START, repeated START, STOP
        set_lines(1'b0, 1'b1, c_EV_START, 1);
        set_lines(1'b0, 1'b0, 0, 0);
        set_lines(1'b1, 1'b0, 0, 0);
        set_lines(1'b1, 1'b1, 0, 0);
        check("busy_hold", int'(bus.bus_busy), 1);
        set_lines(1'b0, 1'b1, c_EV_START, 1);
        set_lines(1'b1, 1'b1, c_EV_STOP, 0);

        // simultaneous fall gives no event; STOP while idle stays idle
        set_lines(1'b0, 1'b0, 0, 0);
        check("simul_no_busy", int'(bus.bus_busy), 0);
        set_lines(1'b0, 1'b1, 0, 0);
        set_lines(1'b1, 1'b1, c_EV_STOP, 0);

        // lost STOP: lines return high without a STOP condition
        set_lines(1'b0, 1'b1, c_EV_START, 1);
        set_lines(1'b0, 1'b0, 0, 0);
        set_lines(1'b1, 1'b0, 0, 0);
`ifdef I2C_BUS_TIMEOUT_EN
        push(c_EV_TMO, 0, -1);
        @(negedge clk);
        bus.SCL_in = 1'b1;
        repeat (c_IDLE_TIMEOUT + 40) @(negedge clk);
        check("timeout_release", int'(bus.bus_busy), 0);
`else
        set_lines(1'b1, 1'b1, 0, 0);
        repeat (c_IDLE_TIMEOUT + 30) @(negedge clk);
        check("no_timeout_busy", int'(bus.bus_busy), 1);
`endif

        // reset while busy: busy clears on the reset edge, no STOP pulse
        set_lines(1'b0, 1'b1, c_EV_START, 1);
        check("busy_before_rst", int'(bus.bus_busy), 1);
        @(negedge clk);
        n_rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_busy", int'(bus.bus_busy), 0);
        check("midrst_stop", int'(bus.stop_detected), 0);
        @(negedge clk);
        bus.SDA_in = 1'b1;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_busy", int'(bus.bus_busy), 0);

        // minimum filtering
        fl = 0;
        bus.filter_len = 4'd0;
        repeat (4) @(negedge clk);
        set_lines(1'b0, 1'b1, c_EV_START, 1);
        set_lines(1'b1, 1'b1, c_EV_STOP, 0);

        repeat (10) @(negedge clk);
        check("sb_drain", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
